// File: rtl/conv_window_3x3_mc_if.sv
// rtl/conv_window_3x3_mc_if.sv - pixel-in / window-out bus bundle for conv_window_3x3_mc
//
// Purpose: groups the input pixel handshake and the registered window output.
// Signals:
//   valid_in    master->slave  data_in valid
//   ready_in    slave->master  beat accepted when valid_in && ready_in
//   data_in     master->slave  one channel word per beat, channel-interleaved raster order
//   window_out  slave->master  9 taps, w0 (top-left) at [DATA_WIDTH-1:0]
//   channel_out slave->master  channel of window_out
//   valid_out   slave->master  window_out/channel_out valid
//   done        slave->master  pulse with the last window of the frame
interface conv_window_3x3_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CH_W       = 1
);
  logic                    valid_in;
  logic                    ready_in;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [9*DATA_WIDTH-1:0] window_out;
  logic [CH_W-1:0]         channel_out;
  logic                    valid_out;
  logic                    done;

  modport master (
    output valid_in, data_in,
    input  ready_in, window_out, channel_out, valid_out, done
  );

  modport slave (
    input  valid_in, data_in,
    output ready_in, window_out, channel_out, valid_out, done
  );
endinterface

// File: rtl/conv_window_3x3_mc.sv
// rtl/conv_window_3x3_mc.sv - multi-channel 3x3 sliding-window generator with same/valid modes
//
// Purpose: buffers two image rows per channel and emits one 3x3 window per beat
// once the window is complete; same mode zero-pads the border and flushes the
// last row internally.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high reset
//   bus    slave modport of conv_window_3x3_mc_if (pixel stream in, windows out)
module conv_window_3x3_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter int CHANNELS   = 1,
  parameter int PADDING    = 1,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_window_3x3_mc_if.slave  bus
);

  localparam int  DEPTH    = IMG_WIDTH * CHANNELS;
  localparam int  IDX_W    = $clog2(DEPTH);
  localparam int  COL_W    = $clog2(IMG_WIDTH);
  // Row counter runs two rows past the image during the flush.
  localparam int  ROW_W    = $clog2(IMG_HEIGHT + 2);
  localparam int  CH_SLOTS = 1 << CH_W;
  localparam bit  PAD      = (PADDING != 0);

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_H    = ROW_W'(IMG_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_H1   = ROW_W'(IMG_HEIGHT + 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]  ch_cnt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [IDX_W-1:0] idx;

  logic                  beat;
  logic                  cnt_clear;
  logic [DATA_WIDTH-1:0] pix;

  logic ch_last, col_last, last_pix, flush_end;

  // lb0 holds the previous row, lb1 the row before it; taps hold the two
  // newest columns per channel (a older, b newer).
  logic [DATA_WIDTH-1:0] lb0   [DEPTH];
  logic [DATA_WIDTH-1:0] lb1   [DEPTH];
  logic [DATA_WIDTH-1:0] tap_a [CH_SLOTS][3];
  logic [DATA_WIDTH-1:0] tap_b [CH_SLOTS][3];
  logic [DATA_WIDTH-1:0] col_new [3];

  logic wrap;
  logic mask_top, mask_bot, mask_left, mask_right;
  logic emit, done_hit;
  logic [9*DATA_WIDTH-1:0] win;

  assign ch_last   = (ch_cnt == CH_LAST);
  assign col_last  = (col == COL_LAST);
  assign last_pix  = (row == ROW_LAST) && col_last && ch_last;
  assign flush_end = (row == ROW_H1) && (col == '0) && ch_last;

  assign bus.ready_in = (state_q == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    beat      = 1'b0;
    cnt_clear = 1'b0;
    pix       = '0;
    case (state_q)
      S_RUN: begin
        beat = bus.valid_in;
        pix  = bus.data_in;
        if (beat && last_pix) begin
          if (PAD) state_d   = S_FLUSH;
          else     cnt_clear = 1'b1;
        end
      end
      S_FLUSH: begin
        beat = 1'b1;
        if (flush_end) begin
          state_d   = S_RUN;
          cnt_clear = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Line-buffer index tracks col*CHANNELS+ch_cnt; each row is exactly DEPTH
  // beats, so it wraps in step with the column counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_cnt <= '0;
      col    <= '0;
      row    <= '0;
      idx    <= '0;
    end else if (beat) begin
      if (cnt_clear) begin
        ch_cnt <= '0;
        col    <= '0;
        row    <= '0;
        idx    <= '0;
      end else begin
        ch_cnt <= ch_last ? '0 : ch_cnt + CH_W'(1);
        idx    <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        if (ch_last) begin
          col <= col_last ? '0 : col + COL_W'(1);
          if (col_last) row <= row + ROW_W'(1);
        end
      end
    end
  end

  assign col_new[0] = lb1[idx];
  assign col_new[1] = lb0[idx];
  assign col_new[2] = pix;

  always_ff @(posedge clk) begin
    if (beat) begin
      lb1[idx] <= lb0[idx];
      lb0[idx] <= pix;
      for (int r = 0; r < 3; r++) begin
        tap_a[ch_cnt][r] <= tap_b[ch_cnt][r];
        tap_b[ch_cnt][r] <= col_new[r];
      end
    end
  end

  // The beat at (row, col) completes the window centred one row up and one
  // column left; at col==0 that centre wraps to the last column two rows up.
  assign wrap       = (col == '0);
  assign mask_top   = PAD && (wrap ? (row == ROW_W'(2)) : (row == ROW_W'(1)));
  assign mask_bot   = PAD && (wrap ? (row == ROW_H1)    : (row == ROW_H));
  assign mask_left  = PAD && (col == COL_W'(1));
  assign mask_right = PAD && wrap;

  assign emit = PAD ? ((row >= ROW_W'(2)) || ((row == ROW_W'(1)) && (col != '0)))
                    : ((row >= ROW_W'(2)) && (col >= COL_W'(2)));

  assign done_hit = PAD ? ((state_q == S_FLUSH) && flush_end) : last_pix;

  always_comb begin
    win = '0;
    for (int r = 0; r < 3; r++) begin
      if (!((r == 0 && mask_top) || (r == 2 && mask_bot))) begin
        if (!mask_left)  win[(3*r)*DATA_WIDTH   +: DATA_WIDTH] = tap_a[ch_cnt][r];
        win[(3*r+1)*DATA_WIDTH +: DATA_WIDTH] = tap_b[ch_cnt][r];
        if (!mask_right) win[(3*r+2)*DATA_WIDTH +: DATA_WIDTH] = col_new[r];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.valid_out   <= 1'b0;
      bus.done        <= 1'b0;
      bus.window_out  <= '0;
      bus.channel_out <= '0;
    end else begin
      bus.valid_out <= beat && emit;
      bus.done      <= beat && emit && done_hit;
      if (beat && emit) begin
        bus.window_out  <= win;
        bus.channel_out <= ch_cnt;
      end
    end
  end

endmodule

// File: doc/conv_window_3x3_mc.md
Name: conv_window_3x3_mc

Overview:
- Parametrised 3x3 sliding-window generator; successor to the single-channel fp32 conv2d front end.
- Accepts a raster-order pixel stream carrying CHANNELS channel-interleaved words per pixel.
- Buffers two image rows per channel and emits one full 3x3 window (9 words) per accepted beat once the window is complete.
- Supports "same" (zero-padded) and "valid" modes and an internal end-of-frame flush, so upstream no longer holds valid_in for WIDTH+1 extra cycles.
- Feeds the per-channel fp multiply-accumulate array.

Parameters:
DATA_WIDTH, 32, word width; opaque to the block (fp32 in practice).
IMG_WIDTH, 56, pixels per row; must be >= 3.
IMG_HEIGHT, 56, rows per frame; must be >= 3.
CHANNELS, 1, channels interleaved per pixel; must be >= 1.
PADDING, 1, 1 = same (zero pad, IMG_WIDTH*IMG_HEIGHT windows/channel); 0 = valid ((IMG_WIDTH-2)*(IMG_HEIGHT-2) windows/channel).
CH_W, max(1,clog2(CHANNELS)), width of channel index.

Ports:
clk  in  1  single clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
valid_in  in  1  data_in valid; beat accepted when valid_in && ready_in.
ready_in  out  1  low only during FLUSH.
data_in  in  DATA_WIDTH  pixel word; channel order 0..CHANNELS-1 per pixel position.
window_out  out  9*DATA_WIDTH  taps w0..w8 in raster order (w0 top-left, w4 centre, w8 bottom-right); w0 at [DATA_WIDTH-1:0].
channel_out  out  CH_W  channel of window_out.
valid_out  out  1  window_out/channel_out valid this cycle.
done  out  1  one-cycle pulse coincident with the last window of the frame.

Behaviour:
- Reset values: ready_in=1, valid_out=0, done=0, window_out=0, channel_out=0.
- Reset clears counters and FSM to RUN. Line-buffer and tap contents need not be cleared; stale contents must never reach window_out, because masking covers every tap not yet written in the current frame.
- Reset mid-frame aborts the frame. The next accepted beat is pixel (0,0), channel 0.
- Beat counters: ch_cnt (0..CHANNELS-1), then col (0..IMG_WIDTH-1), then row. Counters advance on accepted beats and on flush beats only.
- Storage: two line buffers, each IMG_WIDTH*CHANNELS deep. Per row, a 3-deep horizontal tap shift per channel.
- Window timing: a beat at linear pixel index p, channel c, completes the window centred at pixel n = p - IMG_WIDTH - 1, channel c.
  - The window is registered on window_out with valid_out=1 exactly one cycle after that beat.
  - Beats with n < 0 produce no output.
- Masking (same mode): taps outside the image read as 0.
  - Top row zeroed when centre row = 0; bottom row when centre row = IMG_HEIGHT-1.
  - Left column zeroed when centre col = 0; right column when centre col = IMG_WIDTH-1.
  - The wrap case (right taps belonging to the next row) is covered by the right-column mask.
- Valid mode: output only when centre row is in 1..IMG_HEIGHT-2 and centre col is in 1..IMG_WIDTH-2. No masking, no flush.
- FSM:
  - RUN: accept beats; ready_in=1.
  - RUN -> FLUSH: same mode, on acceptance of the last beat (pixel IMG_HEIGHT*IMG_WIDTH-1, channel CHANNELS-1).
  - FLUSH: ready_in=0; valid_in ignored; self-generate (IMG_WIDTH+1)*CHANNELS beats, one per cycle, with zero data.
  - FLUSH -> RUN: after the final flush beat; counters cleared.
  - Valid mode: RUN -> RUN with counters cleared after the last beat.
- done is asserted with the window for centre (IMG_HEIGHT-1,IMG_WIDTH-1), channel CHANNELS-1 (same mode), or centre (IMG_HEIGHT-2,IMG_WIDTH-2), channel CHANNELS-1 (valid mode).
- Next frame: may start on the cycle after the FSM returns to RUN. Frames never mix, because row-0 masking applies to the new frame.
- Gaps: valid_in low inserts bubbles only; valid_out is low in the corresponding cycles. Output content is independent of gap pattern.
- Outputs: window_out and channel_out hold their last value when valid_out=0.

Test Plan:
Common setup: IMG_WIDTH=IMG_HEIGHT=4, CHANNELS=1, pixel p = p+1 (0x1..0x10).
1. PADDING=1, contiguous beats -> 16 windows. First output one cycle after beat p=5: {0,0,0,0,1,2,0,5,6}. ready_in low exactly 5 cycles after beat 15. Last window {11,12,0,15,16,0,0,0,0} with done=1.
2. PADDING=0, contiguous beats -> 4 windows. First output one cycle after p=10: {1,2,3,5,6,7,9,10,11}. Last output one cycle after p=15: {6,7,8,10,11,12,14,15,16} with done=1. ready_in never low.
3. PADDING=1, valid_in low for 3 cycles after every accepted beat -> window sequence identical to scenario 1. valid_out high only one cycle after accepted beats.
4. CHANNELS=2, channel 1 word = 0x100+p+1 -> channel_out alternates 0,1. Channel-1 window centre (0,0) = {0,0,0,0,0x101,0x102,0,0x105,0x106}. Flush lasts 10 cycles. done on the channel-1 window of centre (3,3).
5. reset pulsed asynchronously mid-cycle after beat p=7, then a full frame -> valid_out/done/window_out go 0 immediately. Subsequent outputs match scenario 1 exactly.
6. Two back-to-back frames, second frame pixels = 0x20+p -> second frame's centre (0,0) window = {0,0,0,0,0x20,0x21,0,0x24,0x25}. No first-frame data appears.
